// File: rtl/probe_bank_pkg.sv
// Shared types and helpers for probe_bank: controller state encoding,
// a minimum-one clog2 for address widths, and the even-parity function.
package probe_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // A single-word memory still needs a one-bit address port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/probe_bank_if.sv
// Request/acknowledge access port of probe_bank; master drives requests,
// slave (the bank) returns busy/ack/rdata/err.
interface probe_bank_if
  import probe_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 3
);
  localparam int unsigned CH_W   = $clog2(CHANNELS);
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);

  logic              req;
  logic              we;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic              busy;
  logic              ack;
  logic [WIDTH-1:0]  rdata;
  logic              err;

  modport master (
    output req, we, ch, addr, wdata,
    input  busy, ack, rdata, err
  );

  modport slave (
    input  req, we, ch, addr, wdata,
    output busy, ack, rdata, err
  );

endinterface

// File: rtl/probe_bank_chan.sv
// One probe_bank channel: DEPTH x WIDTH memory plus shadow register, with
// optional per-word parity when PROBE_BANK_PARITY_EN is defined.
module probe_bank_chan
  import probe_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              i_clock,
  input  logic              i_clear_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic [WIDTH-1:0]  o_shadow
`ifdef PROBE_BANK_PARITY_EN
  ,
  output logic              o_rpar
`endif
);

  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_shadow;
  logic             w_addr_ok;

  assign w_addr_ok = ({1'b0, i_addr} < DepthLim);
  assign o_shadow  = r_shadow;

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_shadow <= '0;
    end else if (i_we && w_addr_ok) begin
      r_mem[i_addr] <= i_wdata;
      r_shadow      <= i_wdata;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (w_addr_ok) o_rdata = r_mem[i_addr];
  end

`ifdef PROBE_BANK_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (i_we && w_addr_ok) begin
      r_par[i_addr] <= even_parity(64'(i_wdata));
    end
  end

  always_comb begin
    o_rpar = 1'b0;
    if (w_addr_ok) o_rpar = r_par[i_addr];
  end
`endif

endmodule

// File: rtl/probe_bank.sv
// probe_bank top: IDLE/ACCESS/RESP access controller over CHANNELS channels,
// write counter and registered shadow mux. Option: PROBE_BANK_PARITY_EN.
module probe_bank
  import probe_bank_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 3,
  localparam int unsigned CH_W    = $clog2(CHANNELS),
  localparam int unsigned ADDR_W  = clog2_min1(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_clear_n,
  probe_bank_if.slave      bus,
  input  logic [CH_W-1:0]  i_sel,
  output logic [WIDTH-1:0] o_muxout,
  output logic [31:0]      o_wr_count
`ifdef PROBE_BANK_PARITY_EN
  ,
  output logic             o_parity_err
`endif
);

  localparam logic [CH_W:0]   ChanLim  = (CH_W + 1)'(CHANNELS);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  state_e            r_state, w_state_d;
  logic              r_we;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_err;
  logic [31:0]       r_wr_count;
  logic [WIDTH-1:0]  r_muxout;

  logic [WIDTH-1:0]  w_chan_rdata [CHANNELS];
  logic [WIDTH-1:0]  w_shadow     [CHANNELS];
  logic              w_in_range;
  logic [WIDTH-1:0]  w_sel_rdata;
  logic [WIDTH-1:0]  w_mux_d;
  logic              w_commit_wr;

  assign w_in_range  = ({1'b0, r_ch} < ChanLim) && ({1'b0, r_addr} < DepthLim);
  assign w_commit_wr = (r_state == StAccess) && r_we && w_in_range;

`ifdef PROBE_BANK_PARITY_EN
  logic w_chan_rpar [CHANNELS];
  logic w_sel_rpar;
  logic r_parity_err;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    probe_bank_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_chan (
      .i_clock  (i_clock),
      .i_clear_n(i_clear_n),
      .i_we     (w_commit_wr && (r_ch == CH_W'(g))),
      .i_addr   (r_addr),
      .i_wdata  (r_wdata),
      .o_rdata  (w_chan_rdata[g]),
      .o_shadow (w_shadow[g])
`ifdef PROBE_BANK_PARITY_EN
      ,
      .o_rpar   (w_chan_rpar[g])
`endif
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (bus.req) w_state_d = StAccess;
      StAccess: w_state_d = StResp;
      StResp:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_sel_rdata = '0;
    if (w_in_range) w_sel_rdata = w_chan_rdata[r_ch];
  end

  always_comb begin
    w_mux_d = '0;
    if ({1'b0, i_sel} < ChanLim) w_mux_d = w_shadow[i_sel];
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_ch       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
      r_muxout   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_muxout <= w_mux_d;
      if (r_state == StIdle && bus.req) begin
        r_we    <= bus.we;
        r_ch    <= bus.ch;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
      end
      if (r_state == StAccess) begin
        r_err   <= !w_in_range;
        // Writes and out-of-range reads both leave zero in rdata.
        r_rdata <= r_we ? '0 : w_sel_rdata;
        if (w_commit_wr) r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

`ifdef PROBE_BANK_PARITY_EN
  always_comb begin
    w_sel_rpar = 1'b0;
    if (w_in_range) w_sel_rpar = w_chan_rpar[r_ch];
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_parity_err <= 1'b0;
    end else if (r_state == StAccess && !r_we && w_in_range &&
                 (even_parity(64'(w_sel_rdata)) != w_sel_rpar)) begin
      r_parity_err <= 1'b1;
    end
  end

  assign o_parity_err = r_parity_err;
`endif

  assign bus.busy   = (r_state != StIdle);
  assign bus.ack    = (r_state == StResp);
  assign bus.err    = (r_state == StResp) && r_err;
  assign bus.rdata  = r_rdata;
  assign o_muxout   = r_muxout;
  assign o_wr_count = r_wr_count;

endmodule
